// File: rtl/input_bin_wr_ctrl_pkg.sv
// Shared types, FSM encoding and default geometry for the input-bin write controller.
package input_bin_wr_ctrl_pkg;

    localparam int NUM_UNITS_DEF           = 8;
    localparam int STREAM_WIDTH_DEF        = 8;
    localparam int LOG_STREAM_WIDTH_DEF    = 3;
    localparam int BITS_INPUT_BIN_ADDR_DEF = 5;
    localparam int BIN_DEPTH               = 2 ** BITS_INPUT_BIN_ADDR_DEF;

    typedef logic [BITS_INPUT_BIN_ADDR_DEF-1:0] bin_addr_t;
    typedef logic [BITS_INPUT_BIN_ADDR_DEF:0]   bin_occ_t;
    typedef logic [LOG_STREAM_WIDTH_DEF-1:0]    lane_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_ctrl_state_e;

endpackage

// File: rtl/input_bin_wr_ctrl_ptr_unit.sv
// One circular input bin: write/read pointers, occupancy and the registered write command.
module input_bin_wr_ctrl_ptr_unit #(
    parameter int STREAM_WIDTH        = 8,
    parameter int LOG_STREAM_WIDTH    = 3,
    parameter int BITS_INPUT_BIN_ADDR = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           accept_i,
    input  logic [BITS_INPUT_BIN_ADDR:0]   track_i,
    input  logic [BITS_INPUT_BIN_ADDR-1:0] rd_ctr_i,
    input  logic                           pop_i,
    output logic                           room_o,
    output logic                           occ_zero_o,
    output logic                           underflow_o,
    output logic                           wr_en_o,
    output logic [BITS_INPUT_BIN_ADDR-1:0] wr_addr_o,
    output logic [LOG_STREAM_WIDTH:0]      wr_cnt_o,
    output logic [LOG_STREAM_WIDTH-1:0]    lane_ofs_o,
    output logic [BITS_INPUT_BIN_ADDR-1:0] rd_addr_o,
    output logic                           empty_o
);

    localparam logic [BITS_INPUT_BIN_ADDR:0] ROOM_LIMIT =
        (BITS_INPUT_BIN_ADDR+1)'(2 ** BITS_INPUT_BIN_ADDR - STREAM_WIDTH);

    logic [BITS_INPUT_BIN_ADDR-1:0] wr_ptr_q;
    logic [BITS_INPUT_BIN_ADDR-1:0] rd_ptr_q;
    logic [BITS_INPUT_BIN_ADDR:0]   occ_q;
    logic [BITS_INPUT_BIN_ADDR:0]   occ_d;
    logic [BITS_INPUT_BIN_ADDR:0]   push_cnt;
    logic                           pop_ok;
    logic                           push;
    logic                           unused_rd_hi;

    // Only the lane part of the rd counter matters; the upper bits index the block.
    assign unused_rd_hi = ^rd_ctr_i[BITS_INPUT_BIN_ADDR-1:LOG_STREAM_WIDTH];

    assign pop_ok      = pop_i && (occ_q != '0);
    assign underflow_o = pop_i && (occ_q == '0);
    assign push        = accept_i && (track_i != '0);
    assign push_cnt    = accept_i ? track_i : '0;
    assign occ_d       = occ_q + push_cnt - {{BITS_INPUT_BIN_ADDR{1'b0}}, pop_ok};
    assign room_o      = (occ_d <= ROOM_LIMIT);
    assign occ_zero_o  = (occ_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_cnt_o   <= '0;
            lane_ofs_o <= '0;
            rd_addr_o  <= '0;
            empty_o    <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            wr_en_o <= push;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + track_i[BITS_INPUT_BIN_ADDR-1:0];
                wr_addr_o  <= wr_ptr_q;
                wr_cnt_o   <= track_i[LOG_STREAM_WIDTH:0];
                lane_ofs_o <= rd_ctr_i[LOG_STREAM_WIDTH-1:0];
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Head address and empty flag trail the pointer state by one cycle.
            rd_addr_o <= rd_ptr_q;
            empty_o   <= (occ_q == '0);
        end
    end

endmodule

// File: rtl/input_bin_wr_ctrl.sv
// Turns per-unit counter sets into bin write commands; owns flow control, drain FSM and error flags.
module input_bin_wr_ctrl
    import input_bin_wr_ctrl_pkg::*;
#(
    parameter int NUM_UNITs           = NUM_UNITS_DEF,
    parameter int STREAM_WIDTH        = STREAM_WIDTH_DEF,
    parameter int LOG_STREAM_WIDTH    = LOG_STREAM_WIDTH_DEF,
    parameter int BITS_INPUT_BIN_ADDR = BITS_INPUT_BIN_ADDR_DEF
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          blk_valid_i,
    input  logic                                          blk_last_i,
    input  logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR-1:0] set_rd_ctr_pb_i,
    input  logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR:0]   set_track_ctr_pb_i,
    input  logic [NUM_UNITs-1:0]                          pop_i,
    output logic                                          blk_ready_o,
    output logic [NUM_UNITs-1:0]                          bin_wr_en_o,
    output logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR-1:0] bin_wr_addr_o,
    output logic [NUM_UNITs-1:0][LOG_STREAM_WIDTH:0]      bin_wr_cnt_o,
    output logic [NUM_UNITs-1:0][LOG_STREAM_WIDTH-1:0]    bin_lane_ofs_o,
    output logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR-1:0] bin_rd_addr_o,
    output logic [NUM_UNITs-1:0]                          bin_empty_o,
    output logic                                          drain_done_o,
    output logic                                          err_overflow_o,
    output logic                                          err_underflow_o
);

    wr_ctrl_state_e             state_q;
    logic                       blk_ready_q;
    logic                       accept;
    logic                       stay_run;
    logic [NUM_UNITs-1:0]       room;
    logic [NUM_UNITs-1:0]       occ_zero;
    logic [NUM_UNITs-1:0]       underflow;
    int                         track_sum;

    assign accept      = blk_valid_i && blk_ready_q;
    assign stay_run    = (state_q == RUN) && !(accept && blk_last_i);
    assign blk_ready_o = blk_ready_q;

    for (genvar g = 0; g < NUM_UNITs; g++) begin : g_unit
        input_bin_wr_ctrl_ptr_unit #(
            .STREAM_WIDTH        (STREAM_WIDTH),
            .LOG_STREAM_WIDTH    (LOG_STREAM_WIDTH),
            .BITS_INPUT_BIN_ADDR (BITS_INPUT_BIN_ADDR)
        ) u_ptr (
            .clk         (clk),
            .rst         (rst),
            .accept_i    (accept),
            .track_i     (set_track_ctr_pb_i[g]),
            .rd_ctr_i    (set_rd_ctr_pb_i[g]),
            .pop_i       (pop_i[g]),
            .room_o      (room[g]),
            .occ_zero_o  (occ_zero[g]),
            .underflow_o (underflow[g]),
            .wr_en_o     (bin_wr_en_o[g]),
            .wr_addr_o   (bin_wr_addr_o[g]),
            .wr_cnt_o    (bin_wr_cnt_o[g]),
            .lane_ofs_o  (bin_lane_ofs_o[g]),
            .rd_addr_o   (bin_rd_addr_o[g]),
            .empty_o     (bin_empty_o[g])
        );
    end

    always_comb begin
        track_sum = 0;
        for (int u = 0; u < NUM_UNITs; u++) begin
            track_sum = track_sum + int'(set_track_ctr_pb_i[u]);
        end
    end

    // Every accepted block must distribute exactly one stream width of elements.
    assert property (@(posedge clk) disable iff (rst) accept |-> (track_sum == STREAM_WIDTH));

    // blk_ready is registered, so it is derived from the state and occupancy about to be loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            blk_ready_q     <= 1'b1;
            drain_done_o    <= 1'b0;
            err_overflow_o  <= 1'b0;
            err_underflow_o <= 1'b0;
        end else begin
            drain_done_o <= 1'b0;
            case (state_q)
                RUN: begin
                    if (accept && blk_last_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (&occ_zero) begin
                        state_q      <= DONE;
                        drain_done_o <= 1'b1;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= RUN;
            endcase
            blk_ready_q <= stay_run && (&room);
            if (blk_valid_i && !blk_ready_q) begin
                err_overflow_o <= 1'b1;
            end
            if (|underflow) begin
                err_underflow_o <= 1'b1;
            end
        end
    end

endmodule
